// File: rtl/mem_slot_arbiter.sv
// mem_slot_arbiter
//   Shares the VIC's free low-phase memory slots (idle cycles and sprite-pointer
//   idle gaps) among NUM_REQ extension requesters such as a blitter, a video RAM
//   port or register DMA. It sits beside the cycle sequencer and reads its
//   cycle_type. At most one owner is granted per slot. Ownership is handed out
//   round-robin, and a per-requester starvation flag is kept.
//
//   Build option:
//     SLOT_ARB_FIXED_PRIO0_EN  Requester 0 wins every free slot it asks for.
//                              Its wins do not move the round-robin pointer, and
//                              its wait counter and starve flag stay at 0.
//                              When the macro is undefined, all requesters share
//                              slots by pure round-robin.
//
//   Ports:
//     clk_dot4x          in   4x dot clock; the only clock
//     rst                in   synchronous, active-high reset
//     clk_phi            in   phi level, sampled at phi_phase_start_1
//     phi_phase_start_1  in   one-clk strobe at each phi phase boundary
//     cycle_type         in   current `VIC_* cycle type from the sequencer
//     req                in   level request per requester
//     grant              out  one-hot owner of the current slot, or 0
//     grant_idx          out  binary owner index; valid while slot_busy
//     slot_busy          out  a granted slot is in progress
//     starve             out  requester has been denied MAX_WAIT consecutive free slots

`ifndef VIC_LP
`define VIC_LP   4'd0
`endif
`ifndef VIC_LPI2
`define VIC_LPI2 4'd1
`endif
`ifndef VIC_LS2
`define VIC_LS2  4'd2
`endif
`ifndef VIC_LR
`define VIC_LR   4'd3
`endif
`ifndef VIC_LG
`define VIC_LG   4'd4
`endif
`ifndef VIC_LI
`define VIC_LI   4'd5
`endif

module mem_slot_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_WAIT = 7,
    localparam int IDXW    = $clog2(NUM_REQ)
) (
    input  logic               clk_dot4x,
    input  logic               rst,
    input  logic               clk_phi,
    input  logic               phi_phase_start_1,
    input  logic [3:0]         cycle_type,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDXW-1:0]    grant_idx,
    output logic               slot_busy,
    output logic [NUM_REQ-1:0] starve
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic                      eval_q;     // first clk of the low phase
    logic [IDXW-1:0]           rr_ptr;     // index of the last round-robin winner
    logic [NUM_REQ-1:0][3:0]   wait_cnt;

    logic                      slot_free;
    logic                      pick_valid;
    logic [IDXW-1:0]           pick_idx;
    logic [NUM_REQ-1:0][3:0]   nxt_wait;
    logic [NUM_REQ-1:0]        nxt_starve;

    // Only idle and sprite-pointer idle low phases can be lent out.
    assign slot_free = eval_q &&
                       (cycle_type == `VIC_LI || cycle_type == `VIC_LPI2);

    // Round-robin pick. The scan runs from the farthest candidate to the
    // nearest, so the last hit, which is the one closest after rr_ptr, is kept.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                pick_valid = 1'b1;
                pick_idx   = IDXW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
`ifdef SLOT_ARB_FIXED_PRIO0_EN
        if (req[0]) begin
            pick_valid = 1'b1;
            pick_idx   = '0;
        end
`endif
    end

    // Wait counters. These values are only committed on free slots.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !(pick_valid && int'(pick_idx) == i))
                nxt_wait[i] = (wait_cnt[i] >= WAIT_MAX) ? WAIT_MAX : wait_cnt[i] + 4'd1;
            else
                nxt_wait[i] = 4'd0;
        end
`ifdef SLOT_ARB_FIXED_PRIO0_EN
        nxt_wait[0] = 4'd0;
`endif
        for (int i = 0; i < NUM_REQ; i++)
            nxt_starve[i] = (nxt_wait[i] == WAIT_MAX);
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            eval_q    <= 1'b0;
            rr_ptr    <= IDXW'(NUM_REQ - 1);
            wait_cnt  <= '0;
            grant     <= '0;
            grant_idx <= '0;
            slot_busy <= 1'b0;
            starve    <= '0;
        end else begin
            eval_q <= phi_phase_start_1 && clk_phi;

            // Any phase strobe ends the slot. A low-going strobe is the normal
            // slot end. A high-going strobe only arrives here if the slot end
            // was lost, and that slot must be cleared before the next eval.
            if (phi_phase_start_1) begin
                grant     <= '0;
                slot_busy <= 1'b0;
            end

            if (slot_free) begin
                wait_cnt <= nxt_wait;
                starve   <= nxt_starve;
                if (pick_valid) begin
                    grant     <= NUM_REQ'(1) << pick_idx;
                    grant_idx <= pick_idx;
                    slot_busy <= 1'b1;
`ifdef SLOT_ARB_FIXED_PRIO0_EN
                    if (pick_idx != '0)
                        rr_ptr <= pick_idx;
`else
                    rr_ptr <= pick_idx;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_slot_arbiter.sv
`ifndef VIC_LP
`define VIC_LP   4'd0
`endif
`ifndef VIC_LPI2
`define VIC_LPI2 4'd1
`endif
`ifndef VIC_LS2
`define VIC_LS2  4'd2
`endif
`ifndef VIC_LR
`define VIC_LR   4'd3
`endif
`ifndef VIC_LG
`define VIC_LG   4'd4
`endif
`ifndef VIC_LI
`define VIC_LI   4'd5
`endif

module tb_mem_slot_arbiter;
    localparam int N  = 4;
    localparam int MW = 3;

    logic       clk_dot4x = 1'b0;
    logic       rst = 1'b1;
    logic       clk_phi = 1'b0;
    logic       phi_phase_start_1 = 1'b0;
    logic [3:0] cycle_type = `VIC_LP;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant;
    logic [1:0]   grant_idx;
    logic         slot_busy;
    logic [N-1:0] starve;

    mem_slot_arbiter #(.NUM_REQ(N), .MAX_WAIT(MW)) dut (
        .clk_dot4x(clk_dot4x), .rst(rst), .clk_phi(clk_phi),
        .phi_phase_start_1(phi_phase_start_1), .cycle_type(cycle_type),
        .req(req), .grant(grant), .grant_idx(grant_idx),
        .slot_busy(slot_busy), .starve(starve));

    always #5 clk_dot4x = ~clk_dot4x;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] idx;
        logic [3:0] starve;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: slot-level rules with plain integers.
    int         m_rr;
    int         m_wait[N];
    logic [3:0] m_starve;

    task automatic model_reset();
        m_rr = N - 1;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
        m_starve = '0;
    endtask

    task automatic model_slot(input logic [3:0] ct, input logic [3:0] r);
        exp_t e;
        int   win;
        e.grant = '0;
        e.idx   = '0;
        if (ct == `VIC_LI || ct == `VIC_LPI2) begin
            win = -1;
`ifdef SLOT_ARB_FIXED_PRIO0_EN
            if (r[0]) win = 0;
`endif
            for (int k = 1; k <= N; k++)
                if (win < 0 && r[(m_rr + k) % N]) win = (m_rr + k) % N;
            if (win >= 0) begin
                e.grant = 4'(1 << win);
                e.idx   = 2'(win);
`ifdef SLOT_ARB_FIXED_PRIO0_EN
                if (win != 0) m_rr = win;
`else
                m_rr = win;
`endif
            end
            for (int i = 0; i < N; i++) begin
                if (r[i] && i != win) m_wait[i] = (m_wait[i] + 1 > MW) ? MW : m_wait[i] + 1;
                else                  m_wait[i] = 0;
            end
`ifdef SLOT_ARB_FIXED_PRIO0_EN
            m_wait[0] = 0;
`endif
            for (int i = 0; i < N; i++) m_starve[i] = (m_wait[i] == MW);
        end
        e.starve = m_starve;
        sb_q.push_back(e);
    endtask

    // One phi cycle lasts 8 clks. Clks 0-3 are the high phase, with its strobe
    // on clk 3. Clks 4-7 are the low phase, with its strobe on clk 7.
    task automatic phi_cycle(input logic [3:0] ct, input logic [3:0] r, input logic [3:0] r_mid,
                             input bit do_end, input bit rst_mid);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_dot4x); #1;
            if (i == 0) begin
                req = r;
                model_slot(ct, r);
            end
            clk_phi           = (i < 4);
            phi_phase_start_1 = (i == 3) || (i == 7 && do_end);
            if (i == 4) cycle_type = ct;
            if (i == 5) begin
                req = r_mid;
                if (rst_mid) rst = 1'b1;
            end
            if (i == 6 && rst_mid) begin
                rst = 1'b0;
                model_reset();
            end
        end
    endtask

    // Monitor: tracks slot timing from the observed inputs, pops an expectation
    // on each eval edge and compares all outputs every clk.
    initial begin : monitor
        exp_t       e;
        logic [3:0] e_grant  = '0;
        logic [1:0] e_idx    = '0;
        logic       e_busy   = 1'b0;
        logic [3:0] e_starve = '0;
        bit         eval_pend = 0;
        bit         s_rst, s_st, s_phi;
        forever begin
            @(posedge clk_dot4x);
            s_rst = rst; s_st = phi_phase_start_1; s_phi = clk_phi;
            if (s_rst) begin
                e_grant = '0; e_idx = '0; e_busy = 1'b0; e_starve = '0;
                eval_pend = 0;
            end else begin
                if (s_st) begin
                    e_grant = '0;
                    e_busy  = 1'b0;
                end
                if (eval_pend) begin
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_empty at %0t: got no expectation, required one", $time);
                    end else begin
                        e = sb_q.pop_front();
                        e_starve = e.starve;
                        if (e.grant != '0) begin
                            e_grant = e.grant;
                            e_idx   = e.idx;
                            e_busy  = 1'b1;
                        end
                    end
                end
                eval_pend = s_st && s_phi;
            end
            @(negedge clk_dot4x);
            chk("grant",     8'(grant),     8'(e_grant));
            chk("slot_busy", 8'(slot_busy), 8'(e_busy));
            chk("grant_idx", 8'(grant_idx), 8'(e_idx));
            chk("starve",    8'(starve),    8'(e_starve));
        end
    end

    initial begin : stim
        logic [3:0] types[7];
        types = '{`VIC_LI, `VIC_LI, `VIC_LPI2, `VIC_LP, `VIC_LS2, `VIC_LR, `VIC_LG};
        model_reset();
        // Reset is held for 3 clks while all requesters are asking.
        req = 4'b1111;
        repeat (3) @(posedge clk_dot4x);
        #1 rst = 1'b0;

        // Round robin. After reset, requester 0 wins first.
        for (int s = 0; s < 8; s++) phi_cycle(`VIC_LI, 4'b1111, 4'b1111, 1, 0);
        // Slot typing: only LPI2 can be granted.
        phi_cycle(`VIC_LP,   4'b0010, 4'b0010, 1, 0);
        phi_cycle(`VIC_LS2,  4'b0010, 4'b0010, 1, 0);
        phi_cycle(`VIC_LR,   4'b0010, 4'b0010, 1, 0);
        phi_cycle(`VIC_LG,   4'b0010, 4'b0010, 1, 0);
        phi_cycle(`VIC_LPI2, 4'b0010, 4'b0010, 1, 0);
        // The owner drops req mid-slot, but the grant is held to the slot end.
        phi_cycle(`VIC_LI, 4'b0100, 4'b0000, 1, 0);
        phi_cycle(`VIC_LI, 4'b0101, 4'b0101, 1, 0);
        // Starvation pressure on two requesters.
        for (int s = 0; s < 4; s++) phi_cycle(`VIC_LI, 4'b0011, 4'b0011, 1, 0);
        for (int s = 0; s < 5; s++) phi_cycle(`VIC_LI, 4'b1111, 4'b1111, 1, 0);
        // Free slot with no requests.
        phi_cycle(`VIC_LI, 4'b0000, 4'b0000, 1, 0);
        // Reset mid-slot, after which requester 0 wins again.
        phi_cycle(`VIC_LI, 4'b1000, 4'b1000, 1, 1);
        phi_cycle(`VIC_LI, 4'b1111, 4'b1111, 1, 0);
        // Lost slot end, recovered at the next high strobe.
        phi_cycle(`VIC_LI, 4'b0110, 4'b0110, 0, 0);
        phi_cycle(`VIC_LI, 4'b0110, 4'b0110, 1, 0);

        for (int s = 0; s < 160; s++)
            phi_cycle(types[$urandom_range(0, 6)], 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), $urandom_range(0, 9) != 0,
                      $urandom_range(0, 29) == 0);

        repeat (4) @(posedge clk_dot4x);
        @(negedge clk_dot4x);
        chk("sb_drained", 8'(sb_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
